logistic_hyp_seq: RTL and testbench



---
 rtl/logistic_hyp_seq_pkg.sv | 25 ++
 rtl/logistic_hyp_seq_if.sv | 29 ++
 rtl/logistic_hyp_seq_lut.sv | 70 +++++++
 rtl/logistic_hyp_seq.sv | 163 ++++++++++++++++
 tb/tb_logistic_hyp_seq.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/logistic_hyp_seq_pkg.sv
// Shared constants, FSM state encoding and accumulator-width helper for the
// logistic-regression hypothesis unit (logistic_hyp_seq).
package logreg_pkg;

   localparam int N_FEAT_DEF = 8;
   localparam int DW_DEF     = 8;
   localparam int Z_W_DEF    = 8;
   localparam int Z_FRAC_DEF = 4;
   localparam int H_W_DEF    = 8;

   // Controller state encoding; plain constants keep the encoding visible in
   // waveforms of older tools.
   typedef logic [1:0] hyp_state_t;
   localparam hyp_state_t ST_IDLE   = 2'd0;
   localparam hyp_state_t ST_MAC    = 2'd1;
   localparam hyp_state_t ST_LOOKUP = 2'd2;
   localparam hyp_state_t ST_HOLD   = 2'd3;

   // Signed accumulator width that cannot overflow for n_feat products of
   // two signed dw-bit operands.
   function automatic int acc_width(input int n_feat, input int dw);
      return 2 * dw + $clog2(n_feat);
   endfunction

endpackage

// File: rtl/logistic_hyp_seq_if.sv
// Valid/ready bundle between the feature/weight source, the hypothesis unit
// and the downstream decision/update stage. The unit itself uses 'slave'.
interface logistic_hyp_seq_if
   import logreg_pkg::*;
#(
   parameter int N_FEAT = N_FEAT_DEF,
   parameter int DW     = DW_DEF,
   parameter int Z_W    = Z_W_DEF,
   parameter int H_W    = H_W_DEF
);
   logic                   in_valid;
   logic                   in_ready;
   logic [N_FEAT*DW-1:0]   in_x;
   logic [N_FEAT*DW-1:0]   in_theta;
   logic                   out_valid;
   logic                   out_ready;
   logic [H_W-1:0]         out_h;
   logic [Z_W-1:0]         out_z;

   modport master (
      output in_valid, in_x, in_theta, out_ready,
      input  in_ready, out_valid, out_h, out_z
   );

   modport slave (
      input  in_valid, in_x, in_theta, out_ready,
      output in_ready, out_valid, out_h, out_z
   );
endinterface

// File: rtl/logistic_hyp_seq_lut.sv
// sigmoid_lut_seq: registered sigmoid ROM. Address is a signed Z_W-bit index
// with Z_FRAC fractional bits; data is floor(2^H_W * sigmoid(z)), clipped to
// 2^H_W-1. Contents are computed at elaboration with integer fixed-point math
// so no real-number support is needed from the tools.
module sigmoid_lut_seq #(
   parameter int Z_W    = 8,
   parameter int Z_FRAC = 4,
   parameter int H_W    = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           rd_en_i,
   input  logic [Z_W-1:0] addr_i,
   output logic [H_W-1:0] data_o
);

   localparam int ONE_SH = 56;

   // e^(-1/2^Z_FRAC) by Taylor series, then raised to |z|, all in Q.56.
   // For z >= 0: h = 2^H_W / (1 + e^-t); for z < 0: h = 2^H_W e^t / (1 + e^t).
   function automatic logic [H_W-1:0] lut_entry(input int a);
      int           z;
      int           mag;
      logic [127:0] r;
      logic [127:0] term;
      logic [127:0] p;
      logic [127:0] num;
      logic [127:0] den;
      logic [127:0] h;
      z    = (a >= 2**(Z_W-1)) ? a - 2**Z_W : a;
      mag  = (z < 0) ? -z : z;
      term = 128'd1 << ONE_SH;
      r    = term;
      for (int k = 1; k <= 12; k++) begin
         term = term / (128'(k) << Z_FRAC);
         if (k % 2 == 1) r = r - term;
         else            r = r + term;
      end
      p = 128'd1 << ONE_SH;
      for (int i = 0; i < mag; i++) begin
         p = (p * r) >> ONE_SH;
      end
      den = (128'd1 << ONE_SH) + p;
      if (z >= 0) num = 128'd1 << (ONE_SH + H_W);
      else        num = p << H_W;
      h = num / den;
      if (h > 128'((1 << H_W) - 1)) h = 128'((1 << H_W) - 1);
      return h[H_W-1:0];
   endfunction

   logic [H_W-1:0] rom [2**Z_W];
   logic [H_W-1:0] data_q;

   for (genvar a = 0; a < 2**Z_W; a++) begin : g_rom
      localparam logic [H_W-1:0] ENTRY = lut_entry(a);
      assign rom[a] = ENTRY;
   end

   // Registered read: data appears the cycle after rd_en_i and then holds.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_q <= '0;
      end else if (rd_en_i) begin
         data_q <= rom[addr_i];
      end
   end

   assign data_o = data_q;

endmodule

// File: rtl/logistic_hyp_seq.sv
// logistic_hyp_seq: sequential h = sigmoid(x . theta).
// Captures x/theta on accept, multiply-accumulates LANES products per cycle,
// rescales by FRAC_SHIFT, narrows to the Z_W-bit LUT index and reads a
// registered sigmoid table.
// Build option: define HYP_SAT_EN to clamp the index to the signed Z_W range;
// otherwise the index is the low Z_W bits of the rescaled sum (wraps).
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | in_ready=1, waiting for a vector
// ST_MAC    | accumulating LANES products per cycle
// ST_LOOKUP | narrow sum to index, LUT read issued, out_z/out_h load
// ST_HOLD   | out_valid=1, result held until out_ready
module logistic_hyp_seq
   import logreg_pkg::*;
#(
   parameter int N_FEAT     = N_FEAT_DEF,
   parameter int DW         = DW_DEF,
   parameter int LANES      = 1,
   parameter int ACC_W      = acc_width(N_FEAT, DW),
   parameter int FRAC_SHIFT = 4,
   parameter int Z_W        = Z_W_DEF,
   parameter int Z_FRAC     = Z_FRAC_DEF,
   parameter int H_W        = H_W_DEF
) (
   input  logic                clk,
   input  logic                rst,
   logistic_hyp_seq_if.slave   bus
);

   localparam int IW = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
   localparam logic [IW-1:0] IDX_LAST = IW'(N_FEAT - LANES);
   localparam logic [IW-1:0] IDX_STEP = IW'(LANES);

   hyp_state_t               state_q, state_d;
   logic [N_FEAT*DW-1:0]     x_q, x_d;
   logic [N_FEAT*DW-1:0]     th_q, th_d;
   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic [IW-1:0]            idx_q, idx_d;
   logic [Z_W-1:0]           z_q, z_d;

   logic signed [ACC_W-1:0]  prod_ext [LANES];
   logic signed [ACC_W-1:0]  lane_sum;
   logic [Z_W-1:0]           z_w;
   logic                     lut_rd;
   logic [H_W-1:0]           h_w;

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic signed [DW-1:0]   xe;
      logic signed [DW-1:0]   te;
      logic signed [2*DW-1:0] prod;
      assign xe          = x_q[(int'(idx_q) + l)*DW +: DW];
      assign te          = th_q[(int'(idx_q) + l)*DW +: DW];
      assign prod        = xe * te;
      assign prod_ext[l] = {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
   end

   // Sum of this cycle's lane products.
   always_comb begin
      lane_sum = '0;
      for (int l = 0; l < LANES; l++) begin
         lane_sum = lane_sum + prod_ext[l];
      end
   end

`ifdef HYP_SAT_EN
   localparam logic signed [ACC_W-1:0] Z_HI = ACC_W'(2**(Z_W-1) - 1);
   localparam logic signed [ACC_W-1:0] Z_LO = ACC_W'(-(2**(Z_W-1)));
   logic signed [ACC_W-1:0] s_w;
   assign s_w = acc_q >>> FRAC_SHIFT;

   // Clamp the rescaled sum into the signed index range.
   always_comb begin
      if (s_w > Z_HI) begin
         z_w = {1'b0, {(Z_W-1){1'b1}}};
      end else if (s_w < Z_LO) begin
         z_w = {1'b1, {(Z_W-1){1'b0}}};
      end else begin
         z_w = s_w[Z_W-1:0];
      end
   end
`else
   // Low Z_W bits of acc >>> FRAC_SHIFT; caller guarantees range.
   assign z_w = acc_q[FRAC_SHIFT +: Z_W];
`endif

   // Next-state and datapath update for the sequencer.
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      th_d    = th_q;
      acc_d   = acc_q;
      idx_d   = idx_q;
      z_d     = z_q;
      lut_rd  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.in_valid) begin
               x_d     = bus.in_x;
               th_d    = bus.in_theta;
               acc_d   = '0;
               idx_d   = '0;
               state_d = ST_MAC;
            end
         end
         ST_MAC: begin
            acc_d = acc_q + lane_sum;
            idx_d = idx_q + IDX_STEP;
            if (idx_q == IDX_LAST) begin
               state_d = ST_LOOKUP;
            end
         end
         ST_LOOKUP: begin
            z_d     = z_w;
            lut_rd  = 1'b1;
            state_d = ST_HOLD;
         end
         ST_HOLD: begin
            if (bus.out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         x_q     <= '0;
         th_q    <= '0;
         acc_q   <= '0;
         idx_q   <= '0;
         z_q     <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         th_q    <= th_d;
         acc_q   <= acc_d;
         idx_q   <= idx_d;
         z_q     <= z_d;
      end
   end

   sigmoid_lut_seq #(
      .Z_W    (Z_W),
      .Z_FRAC (Z_FRAC),
      .H_W    (H_W)
   ) u_lut (
      .clk     (clk),
      .rst     (rst),
      .rd_en_i (lut_rd),
      .addr_i  (z_w),
      .data_o  (h_w)
   );

   assign bus.in_ready  = (state_q == ST_IDLE);
   assign bus.out_valid = (state_q == ST_HOLD);
   assign bus.out_h     = h_w;
   assign bus.out_z     = z_q;

endmodule

// File: tb/tb_logistic_hyp_seq.sv
// Directed bench for logistic_hyp_seq: one LANES=1 instance and one LANES=4
// instance, hand-computed expected index/hypothesis values and latencies.
module tb_logistic_hyp_seq;
   import logreg_pkg::*;

   localparam int NF = 8;
   localparam int DW = 8;

`ifdef HYP_SAT_EN
   localparam int EZ_POS = 127;
   localparam int EH_POS = 255;
   localparam int EZ_NEG = -128;
   localparam int EH_NEG = 0;
`else
   localparam int EZ_POS = -128;
   localparam int EH_POS = 0;
   localparam int EZ_NEG = 64;
   localparam int EH_NEG = 251;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logistic_hyp_seq_if #(.N_FEAT(NF), .DW(DW), .Z_W(8), .H_W(8)) bus1 ();
   logistic_hyp_seq_if #(.N_FEAT(NF), .DW(DW), .Z_W(8), .H_W(8)) bus4 ();

   logistic_hyp_seq #(.N_FEAT(NF), .DW(DW), .LANES(1)) u_dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   logistic_hyp_seq #(.N_FEAT(NF), .DW(DW), .LANES(4)) u_dut4 (
      .clk (clk),
      .rst (rst),
      .bus (bus4)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_val(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] rep8(input logic [7:0] v);
      return {8{v}};
   endfunction

   // One transaction on the LANES=1 instance, with optional output stall.
   task automatic run1(input string tag, input logic [63:0] x, input logic [63:0] th,
                       input int ez, input int eh, input int stall);
      int lat;
      @(negedge clk);
      check_val({tag, ".in_ready"}, int'(bus1.in_ready), 1);
      bus1.in_x     = x;
      bus1.in_theta = th;
      bus1.in_valid = 1'b1;
      @(negedge clk);
      bus1.in_valid = 1'b0;
      bus1.in_x     = '1;
      bus1.in_theta = rep8(8'h80);
      lat = 1;
      while (!bus1.out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check_val({tag, ".latency"}, lat, NF + 2);
      check_val({tag, ".out_z"}, int'($signed(bus1.out_z)), ez);
      check_val({tag, ".out_h"}, int'(bus1.out_h), eh);
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         check_val({tag, ".hold_z"}, int'($signed(bus1.out_z)), ez);
         check_val({tag, ".hold_h"}, int'(bus1.out_h), eh);
         check_val({tag, ".hold_valid"}, int'(bus1.out_valid), 1);
         check_val({tag, ".hold_in_ready"}, int'(bus1.in_ready), 0);
      end
      bus1.out_ready = 1'b1;
      @(negedge clk);
      bus1.out_ready = 1'b0;
      check_val({tag, ".valid_drop"}, int'(bus1.out_valid), 0);
      check_val({tag, ".ready_back"}, int'(bus1.in_ready), 1);
   endtask

   initial begin
      logic [63:0] x4;
      int          lat;
      bit          seen;

      bus1.in_valid = 1'b0; bus1.in_x = '0; bus1.in_theta = '0; bus1.out_ready = 1'b0;
      bus4.in_valid = 1'b0; bus4.in_x = '0; bus4.in_theta = '0; bus4.out_ready = 1'b0;

      repeat (3) @(negedge clk);
      check_val("reset.in_ready", int'(bus1.in_ready), 1);
      check_val("reset.out_valid", int'(bus1.out_valid), 0);
      check_val("reset.out_h", int'(bus1.out_h), 0);
      check_val("reset.out_z", int'(bus1.out_z), 0);
      rst = 1'b0;

      run1("zero_x", 64'h0, 64'h5A3C_F081_7F80_12ED, 0, 128, 0);
      run1("pos_big", rep8(8'd127), rep8(8'd127), EZ_POS, EH_POS, 0);
      run1("neg_big", rep8(8'd127), rep8(8'h80), EZ_NEG, EH_NEG, 0);
      run1("z_m16", rep8(8'd16), rep8(8'hFE), -16, 68, 0);
      run1("backpressure", rep8(8'd16), rep8(8'd2), 16, 187, 5);

      // Reset on the 4th MAC cycle must discard the in-flight result.
      @(negedge clk);
      bus1.in_x     = rep8(8'd127);
      bus1.in_theta = rep8(8'd127);
      bus1.in_valid = 1'b1;
      @(negedge clk);
      bus1.in_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_val("midrst.in_ready", int'(bus1.in_ready), 1);
      check_val("midrst.out_h", int'(bus1.out_h), 0);
      check_val("midrst.out_z", int'(bus1.out_z), 0);
      seen = 1'b0;
      repeat (15) begin
         @(negedge clk);
         if (bus1.out_valid) seen = 1'b1;
      end
      check_val("midrst.no_out_valid", int'(seen), 0);
      run1("after_rst", 64'h0, 64'h0, 0, 128, 0);

      // LANES=4 instance: x = 1..8, theta = 16 -> acc 576, z 36, h 231.
      for (int i = 0; i < NF; i++) x4[i*8 +: 8] = 8'(i + 1);
      @(negedge clk);
      check_val("lanes4.in_ready", int'(bus4.in_ready), 1);
      bus4.in_x     = x4;
      bus4.in_theta = rep8(8'd16);
      bus4.in_valid = 1'b1;
      @(negedge clk);
      bus4.in_valid = 1'b0;
      bus4.in_x     = '0;
      lat = 1;
      while (!bus4.out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check_val("lanes4.latency", lat, NF / 4 + 2);
      check_val("lanes4.out_z", int'($signed(bus4.out_z)), 36);
      check_val("lanes4.out_h", int'(bus4.out_h), 231);
      bus4.out_ready = 1'b1;
      @(negedge clk);
      bus4.out_ready = 1'b0;
      check_val("lanes4.valid_drop", int'(bus4.out_valid), 0);
      check_val("lanes4.ready_back", int'(bus4.in_ready), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
